// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_ADDR_W  = 32;
  localparam int FETCH_INSTR_W = 32;
  localparam int FETCH_DEPTH   = 2;
  localparam int FETCH_CNT_W   = $clog2(FETCH_DEPTH + 1);

  localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Bundle of PC, instruction-memory and decode signals seen by the fetch unit.
interface fetch_if
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = FETCH_ADDR_W,
  parameter int INSTR_WIDTH = FETCH_INSTR_W
);

  logic [ADDR_WIDTH-1:0]  pc_in;
  logic                   pc_enable;
  logic                   pc_load;
  logic [ADDR_WIDTH-1:0]  pc_load_val;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   imem_req_valid;
  logic                   imem_req_ready;
  logic [ADDR_WIDTH-1:0]  imem_req_addr;
  logic                   imem_resp_valid;
  logic [INSTR_WIDTH-1:0] imem_resp_data;
  logic                   id_valid;
  logic                   id_ready;
  logic [INSTR_WIDTH-1:0] id_instr;
  logic [ADDR_WIDTH-1:0]  id_pc;

  modport master (
    input  pc_in, redirect_valid, redirect_pc, imem_req_ready,
           imem_resp_valid, imem_resp_data, id_ready,
    output pc_enable, pc_load, pc_load_val, imem_req_valid, imem_req_addr,
           id_valid, id_instr, id_pc
  );

  modport slave (
    output pc_in, redirect_valid, redirect_pc, imem_req_ready,
           imem_resp_valid, imem_resp_data, id_ready,
    input  pc_enable, pc_load, pc_load_val, imem_req_valid, imem_req_addr,
           id_valid, id_instr, id_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from storage registers.
module fetch_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  T                           data_i,
  input  logic                       pop_i,
  output T                           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_C = DEPTH[CNT_W-1:0];

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty_s, full_s, do_push_s, do_pop_s;

  assign empty_s   = (count_q == '0);
  assign full_s    = (count_q == FULL_C);
  assign do_pop_s  = pop_i && !empty_s;
  // A full queue may still accept a push when the head leaves in the same cycle.
  assign do_push_s = push_i && (!full_s || do_pop_s);

  // Pointer and occupancy next state; flush empties the queue.
  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush_i) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      rd_d    = do_pop_s  ? rd_q + PTR_W'(1) : rd_q;
      wr_d    = do_push_s ? wr_q + PTR_W'(1) : wr_q;
      count_d = count_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  // Payload storage.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited in-order requests, PC/instruction
// queues feeding decode, and wrong-path discard after a redirect.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH  = FETCH_ADDR_W,
  parameter int INSTR_WIDTH = FETCH_INSTR_W,
  parameter int DEPTH       = FETCH_DEPTH
) (
  input logic     clk,
  input logic     reset,
  fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] CAP_C = DEPTH[CNT_W:0];

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [CNT_W-1:0]      inflight_q, inflight_d, drop_q, drop_d, occ_s, tag_cnt_s;
  logic [CNT_W:0]        load_s;
  logic                  req_valid_s, fire_s, keep_s, id_valid_s, pop_s;
  logic [ADDR_WIDTH-1:0] tag_pc_s;
  entry_t                push_entry_s, head_s;

  // Credits: outstanding requests plus queued entries never exceed DEPTH,
  // so every kept response is guaranteed a free slot.
  assign load_s      = {1'b0, inflight_q} + {1'b0, occ_s};
  assign req_valid_s = !reset && !bus.redirect_valid && (load_s < CAP_C);
  assign fire_s      = req_valid_s && bus.imem_req_ready;
  assign keep_s      = bus.imem_resp_valid && (drop_q == '0) && (tag_cnt_s != '0)
                       && !bus.redirect_valid;
  assign id_valid_s  = !reset && (occ_s != '0);
  assign pop_s       = id_valid_s && bus.id_ready;
  assign push_entry_s = {tag_pc_s, bus.imem_resp_data};

  fetch_fifo #(.T(logic [ADDR_WIDTH-1:0]), .DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.redirect_valid),
    .push_i  (fire_s),
    .data_i  (bus.pc_in),
    .pop_i   (keep_s),
    .data_o  (tag_pc_s),
    .count_o (tag_cnt_s)
  );

  fetch_fifo #(.T(entry_t), .DEPTH(DEPTH)) u_instr_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (bus.redirect_valid),
    .push_i  (keep_s),
    .data_i  (push_entry_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .count_o (occ_s)
  );

  // Outstanding-request and wrong-path drop bookkeeping.
  always_comb begin
    inflight_d = inflight_q + CNT_W'(fire_s) - CNT_W'(bus.imem_resp_valid);
    if (bus.redirect_valid) begin
      drop_d = inflight_q - CNT_W'(bus.imem_resp_valid);
    end else if (bus.imem_resp_valid && (drop_q != '0)) begin
      drop_d = drop_q - CNT_W'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.pc_enable      = fire_s;
  assign bus.pc_load        = bus.redirect_valid && !reset;
  assign bus.pc_load_val    = bus.redirect_pc;
  assign bus.imem_req_valid = req_valid_s;
  assign bus.imem_req_addr  = bus.pc_in;
  assign bus.id_valid       = id_valid_s;
  assign bus.id_instr       = head_s.instr;
  assign bus.id_pc          = head_s.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: PC and 1-cycle memory models drive the DUT,
// a scoreboard queue holds expected decode entries and a monitor checks pops.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

  fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  int           n_pe;
  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;
  logic [31:0]  mem_q[$];
  logic [31:0]  pc_m;
  logic         mem_hold;
  logic         fire_l, pcen_l, load_l;
  logic [31:0]  addr_l, load_val_l;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    if (a == 32'd0) return NOP_INSTR;
    else if (a == 32'd1) return 32'h0000_0093;
    else return {8'hA5, a[23:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic expect_entry(input logic [31:0] a);
    fetch_entry_t e;
    e.pc    = a;
    e.instr = instr_of(a);
    exp_q.push_back(e);
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_m      = v;
    bus.pc_in = v;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Capture this cycle's handshakes, then update PC and memory models after the edge.
  task automatic to_next();
    logic [31:0] a;
    fire_l     = bus.imem_req_valid && bus.imem_req_ready;
    pcen_l     = bus.pc_enable;
    load_l     = bus.pc_load;
    load_val_l = bus.pc_load_val;
    addr_l     = bus.imem_req_addr;
    @(posedge clk);
    #1;
    if (load_l) pc_m = load_val_l;
    else if (pcen_l) pc_m = pc_m + 32'd1;
    bus.pc_in = pc_m;
    if (fire_l) mem_q.push_back(addr_l);
    if (!mem_hold && mem_q.size() > 0) begin
      a = mem_q.pop_front();
      bus.imem_resp_valid = 1'b1;
      bus.imem_resp_data  = instr_of(a);
    end else begin
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = 32'd0;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      at_neg();
      to_next();
    end
  endtask

  // Scoreboard monitor: every decode handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop: got id_pc %h, required no entry", bus.id_pc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("id_pc", bus.id_pc, mon_e.pc);
        chk("id_instr", bus.id_instr, mon_e.instr);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.pc_in = 32'd0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.imem_req_ready = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = 32'd0;
    bus.id_ready = 1'b0;
    mem_hold = 1'b0;
    pc_m = 32'd0;

    // 1: reset state, then fetch 0 and 1 with minimum latency
    at_neg();
    chk1("rst_id_valid", bus.id_valid, 1'b0);
    chk1("rst_req_valid", bus.imem_req_valid, 1'b0);
    to_next();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h44;
    at_neg();
    chk1("rst_pc_load", bus.pc_load, 1'b0);
    chk1("rst_pc_enable", bus.pc_enable, 1'b0);
    chk1("rst_req_valid_redir", bus.imem_req_valid, 1'b0);
    to_next();
    reset = 1'b0;
    bus.redirect_valid = 1'b0;
    set_pc(32'd0);
    bus.id_ready = 1'b1;
    at_neg();
    chk1("t1_en0", bus.pc_enable, 1'b1);
    chk("t1_addr0", bus.imem_req_addr, 32'd0);
    chk1("t1_idv_n", bus.id_valid, 1'b0);
    expect_entry(32'd0);
    to_next();
    at_neg();
    chk1("t1_en1", bus.pc_enable, 1'b1);
    chk("t1_addr1", bus.imem_req_addr, 32'd1);
    chk1("t1_idv_n1", bus.id_valid, 1'b0);
    expect_entry(32'd1);
    to_next();
    bus.imem_req_ready = 1'b0;
    at_neg();
    chk1("t1_idv_n2", bus.id_valid, 1'b1);
    to_next();
    cycles(3);
    chk("t1_drained", 32'(exp_q.size()), 32'd0);

    // 2: decode stalled, queue fills and requests stop
    bus.id_ready = 1'b0;
    bus.imem_req_ready = 1'b1;
    expect_entry(32'd2);
    expect_entry(32'd3);
    n_pe = 0;
    for (int i = 0; i < 10; i++) begin
      at_neg();
      if (bus.pc_enable === 1'b1) n_pe++;
      to_next();
    end
    at_neg();
    chk("t2_req_count", 32'(n_pe), 32'd2);
    chk1("t2_req_valid", bus.imem_req_valid, 1'b0);
    chk1("t2_pc_enable", bus.pc_enable, 1'b0);
    chk1("t2_id_valid", bus.id_valid, 1'b1);
    chk("t2_head_pc", bus.id_pc, 32'd2);
    chk("t2_head_instr", bus.id_instr, instr_of(32'd2));
    chk("t2_pc", pc_m, 32'd4);
    to_next();
    bus.id_ready = 1'b1;
    bus.imem_req_ready = 1'b0;
    cycles(4);
    chk("t2_drained", 32'(exp_q.size()), 32'd0);

    // 3: memory not ready, PC must hold
    n_pe = 0;
    for (int i = 0; i < 5; i++) begin
      at_neg();
      if (bus.pc_enable === 1'b1) n_pe++;
      chk1("t3_req_offered", bus.imem_req_valid, 1'b1);
      to_next();
    end
    chk("t3_req_count", 32'(n_pe), 32'd0);
    chk("t3_pc_held", pc_m, 32'd4);
    bus.imem_req_ready = 1'b1;
    at_neg();
    chk1("t3_en", bus.pc_enable, 1'b1);
    chk("t3_addr", bus.imem_req_addr, 32'd4);
    expect_entry(32'd4);
    to_next();
    bus.imem_req_ready = 1'b0;
    cycles(3);
    chk("t3_drained", 32'(exp_q.size()), 32'd0);

    // 4: redirect with two requests in flight
    mem_hold = 1'b1;
    bus.imem_req_ready = 1'b1;
    cycles(2);
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h40;
    at_neg();
    chk1("t4_pc_load", bus.pc_load, 1'b1);
    chk("t4_load_val", bus.pc_load_val, 32'h40);
    chk1("t4_no_req", bus.imem_req_valid, 1'b0);
    to_next();
    bus.redirect_valid = 1'b0;
    mem_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk1("t4_pc_load_off", bus.pc_load, 1'b0);
      chk1("t4_dropped", bus.id_valid, 1'b0);
      to_next();
    end
    bus.imem_req_ready = 1'b1;
    at_neg();
    chk1("t4_en", bus.pc_enable, 1'b1);
    chk("t4_addr", bus.imem_req_addr, 32'h40);
    expect_entry(32'h40);
    to_next();
    bus.imem_req_ready = 1'b0;
    cycles(3);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);

    // 5: redirect coinciding with a response and a decode pop
    bus.id_ready = 1'b0;
    bus.imem_req_ready = 1'b1;
    at_neg();
    chk("t5_addr0", bus.imem_req_addr, 32'h41);
    expect_entry(32'h41);
    to_next();
    at_neg();
    chk1("t5_en1", bus.pc_enable, 1'b1);
    to_next();
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h80;
    bus.id_ready = 1'b1;
    at_neg();
    chk1("t5_pc_load", bus.pc_load, 1'b1);
    chk1("t5_id_valid", bus.id_valid, 1'b1);
    to_next();
    bus.redirect_valid = 1'b0;
    at_neg();
    chk1("t5_flushed", bus.id_valid, 1'b0);
    chk1("t5_credit_free", bus.imem_req_valid, 1'b1);
    to_next();
    bus.imem_req_ready = 1'b1;
    at_neg();
    chk("t5_addr_new", bus.imem_req_addr, 32'h80);
    expect_entry(32'h80);
    to_next();
    bus.imem_req_ready = 1'b0;
    cycles(3);
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // 6: reset with a full queue, then reset in the middle of a drop
    bus.id_ready = 1'b0;
    bus.imem_req_ready = 1'b1;
    cycles(3);
    at_neg();
    chk1("t6_full_valid", bus.id_valid, 1'b1);
    chk1("t6_full_noreq", bus.imem_req_valid, 1'b0);
    to_next();
    reset = 1'b1;
    at_neg();
    chk1("t6_rst_id_valid", bus.id_valid, 1'b0);
    chk1("t6_rst_req", bus.imem_req_valid, 1'b0);
    to_next();
    reset = 1'b0;
    set_pc(32'h90);
    mem_hold = 1'b1;
    at_neg();
    chk1("t6_after_rst_idv", bus.id_valid, 1'b0);
    chk("t6_restart_addr", bus.imem_req_addr, 32'h90);
    chk1("t6_restart_en", bus.pc_enable, 1'b1);
    to_next();
    cycles(1);
    bus.imem_req_ready = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hC0;
    cycles(1);
    bus.redirect_valid = 1'b0;
    mem_hold = 1'b0;
    cycles(1);
    at_neg();
    chk1("t6_mid_drop", bus.id_valid, 1'b0);
    to_next();
    reset = 1'b1;
    at_neg();
    chk1("t6_rst2_en", bus.pc_enable, 1'b0);
    chk1("t6_rst2_req", bus.imem_req_valid, 1'b0);
    to_next();
    reset = 1'b0;
    set_pc(32'hD0);
    bus.imem_req_ready = 1'b1;
    bus.id_ready = 1'b1;
    at_neg();
    chk("t6_addr_d0", bus.imem_req_addr, 32'hD0);
    expect_entry(32'hD0);
    to_next();
    bus.imem_req_ready = 1'b0;
    cycles(4);
    chk("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
